// File: rtl/run_det_pkg.sv
// rtl/run_det_pkg.sv - shared state encoding and output mode constants for run_detector
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HIT,
    HOLD
  } run_state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // A clear that coincides with an increment leaves the count at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_detector.sv
// rtl/run_detector.sv - consecutive-bit run detector with level/pulse flag and run statistics
import run_det_pkg::*;

module run_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 4,
  parameter int HIT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_bit,
  input  logic             target,
  input  logic             mode,
  input  logic             clr_hits,
  output logic             out_bit,
  output logic [CNT_W-1:0] run_len,
  output logic [HIT_W-1:0] hits
);

  localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(RUN_LEN - 1);

  run_state_t state, state_nxt;
  logic       target_q;
  logic       target_chg;
  logic       match;
  logic       miss;
  logic       out_q;
  logic       out_nxt;
  logic       hit_entry;

  // A target change discards the sample of that cycle.
  assign target_chg = (target != target_q);
  assign match      = en && (in_bit == target) && !target_chg;
  assign miss       = en && (in_bit != target) && !target_chg;
  assign hit_entry  = (state_nxt == HIT);

  always_comb begin
    state_nxt = state;
    if (target_chg || miss) begin
      state_nxt = IDLE;
    end else if (match) begin
      case (state)
        IDLE:     state_nxt = (RUN_LEN == 1) ? HIT : RUN;
        RUN:      state_nxt = (run_len == LAST_RUN) ? HIT : RUN;
        HIT:      state_nxt = HOLD;
        HOLD:     state_nxt = HOLD;
        default:  state_nxt = IDLE;
      endcase
    end else if (state == HIT) begin
      state_nxt = HOLD;
    end
  end

  always_comb begin
    out_nxt = 1'b0;
    if (state_nxt == HIT) begin
      out_nxt = 1'b1;
    end else if ((state_nxt == HOLD) && (mode == MODE_LEVEL)) begin
      out_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      target_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      target_q <= target;
      out_q    <= out_nxt;
    end
  end

  assign out_bit = out_q;

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (target_chg || miss),
    .q     (run_len)
  );

  sat_counter #(.W(HIT_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_entry),
    .clr   (clr_hits),
    .q     (hits)
  );

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised consecutive-bit run detector, the general successor of the fixed 3-ones sequence FSM. It watches a serial bit stream qualified by `en` and flags when `RUN_LEN` consecutive samples equal a selectable target value. It offers a level or single-pulse output mode and exposes the live run length and a saturating count of detected runs. It sits directly behind serial receivers as a framing/idle/break detector.

## Interface
- `RUN_LEN`, 3: consecutive matching samples required for a detection; must be ≥ 1.
- `CNT_W`, 4: width of `run_len`; must be ≥ $clog2(RUN_LEN+1).
- `HIT_W`, 8: width of `hits`.
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `en`  input  1  sample qualifier; `in_bit` is consumed only when high.
- `in_bit`  input  1  serial data.
- `target`  input  1  bit value being counted (0 or 1).
- `mode`  input  1  0 = level output, 1 = pulse output.
- `clr_hits`  input  1  synchronous clear of `hits`.
- `out_bit`  output  1  detection flag.
- `run_len`  output  CNT_W  current run of matching samples, saturating at all-ones.
- `hits`  output  HIT_W  number of detections since reset or clear, saturating at all-ones.

## Operation
- States: IDLE (run 0), RUN (0 < run < RUN_LEN), HIT (first cycle at run ≥ RUN_LEN), HOLD (run continuing past detection).
- Match means `en` is high and `in_bit` equals `target`. Mismatch means `en` is high and `in_bit` differs from `target`.
- With `en` low, the state, `run_len` and `hits` hold. The only exception is HIT, which always leaves after one cycle and goes to HOLD.
- On a match, `run_len` increments (saturating) and the state advances:
  - IDLE → RUN, or IDLE → HIT when RUN_LEN = 1.
  - RUN → HIT when the new count equals RUN_LEN.
  - HIT → HOLD, and HOLD → HOLD.
- On a mismatch, any state goes to IDLE and `run_len` returns to 0.
- `target` is registered internally. A cycle in which `target` differs from its registered copy forces IDLE with `run_len` = 0, and that cycle's sample is discarded.
- `hits` increments once on every entry to HIT, saturating. A single unbroken run counts once, however long it lasts.
- `clr_hits` zeroes `hits`. If it coincides with a HIT entry, `hits` becomes 1.
- `out_bit`:
  - mode 0: high while in HIT or HOLD.
  - mode 1: high only in HIT, so exactly one cycle per run.
  - `mode` may change at any time and takes effect on the next output value. It does not alter state.

## Timing
- Reset (asynchronous assertion): state IDLE, `out_bit` 0, `run_len` 0, `hits` 0, registered `target` 0. Deassertion is synchronous to `clk` upstream.
- Latency: the RUN_LEN-th matching sample is captured on edge k, and `out_bit` is high in the cycle after edge k. Nothing is combinational from `in_bit` to any output.
- `out_bit`, `run_len` and `hits` are all registered or decoded from registered state only.
- If `reset` is asserted mid-run, all outputs clear immediately and the run restarts from zero.
- `run_len` saturating at 2^CNT_W−1 does not affect HOLD or `out_bit`.

## Structure
- Package `run_det_pkg`: state enum typedef `run_state_t` (IDLE, RUN, HIT, HOLD) and mode constants `MODE_LEVEL`/`MODE_PULSE`.
- Sub-module `sat_counter` (parameter W; ports inc, clr, q; asynchronous active-low reset) is instantiated twice, once for `run_len` and once for `hits`.
- The top level holds the FSM, the registered `target`, and the output decode.

## Test plan
- RUN_LEN=3, target=1, mode=0, en=1, stream 1,1,0,1,1,1,1,0 → `out_bit` high in the 2 cycles after the 6th and 7th samples, then low; `hits` = 1; `run_len` sequence 1,2,0,1,2,3,4,0.
- Same stream with mode=1 → `out_bit` high exactly one cycle (after the 6th sample); `hits` = 1.
- target=0, stream 0,0,en low ×3 cycles,0 → detection after the 3rd qualified zero; `run_len` holds at 2 during the gap.
- RUN_LEN=1, target=1, stream 1,0,1,0 → mode 1 pulses twice; `hits` = 2. HIT_W=2 with 5 such runs → `hits` sticks at 3. `clr_hits` coincident with a HIT entry → `hits` = 1.
- Mid-run `target` toggle after two ones → `run_len` 0 and no detection. `reset` pulsed low asynchronously between edges while in HOLD → all outputs 0 immediately, before the next edge.
